// File: rtl/ram_pkg.sv
// Shared command encoding, per-side control states and reset values for param_ram.
package ram_pkg;

  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdData = 2'b11
  } cmd_e;

  typedef enum logic {
    StIdle,
    StArmed
  } side_state_e;

  localparam side_state_e RstState   = StIdle;
  localparam logic        RstTxValid = 1'b0;
  localparam logic        RstErr     = 1'b0;
  // Replicated across the data width to form the dout reset value.
  localparam logic        RstDoutBit = 1'b0;

endpackage

// File: rtl/ram_array.sv
// Word storage: one write port and one registered read port. Reset clears only the
// read register, never the array itself.
module ram_array
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DATA_W{RstDoutBit}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_ram.sv
// Command-driven RAM: address/data commands arrive on din, each side (read/write) runs
// its own IDLE/ARMED control with optional post-access increment and range checking.
module param_ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned AUTO_INC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LastAddr) ? '0 : a + 1'b1;
  endfunction

  cmd_e              cmd;
  logic [ADDR_W-1:0] pay_addr;
  logic              addr_ok;
  logic              is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;

  side_state_e       wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic              tx_valid_q, err_q, err_d;
  logic              mem_we, mem_re;

  assign cmd        = cmd_e'(din[DATA_W+1:DATA_W]);
  assign pay_addr   = din[ADDR_W-1:0];
  // Widened compare so MEM_DEPTH == 2**ADDR_W does not overflow.
  assign addr_ok    = {1'b0, pay_addr} < DepthW;
  assign is_wr_addr = rx_valid && (cmd == CmdWrAddr);
  assign is_wr_data = rx_valid && (cmd == CmdWrData);
  assign is_rd_addr = rx_valid && (cmd == CmdRdAddr);
  assign is_rd_data = rx_valid && (cmd == CmdRdData);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= RstState;
      rd_state_q <= RstState;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= RstTxValid;
      err_q      <= RstErr;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= mem_re;
      err_q      <= err_d;
    end
  end

  // Next-state logic: an address command arms its side if in range, disarms otherwise.
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    unique case (wr_state_q)
      StIdle:  if (is_wr_addr && addr_ok) wr_state_d = StArmed;
      StArmed: if (is_wr_addr && !addr_ok) wr_state_d = StIdle;
    endcase
    unique case (rd_state_q)
      StIdle:  if (is_rd_addr && addr_ok) rd_state_d = StArmed;
      StArmed: if (is_rd_addr && !addr_ok) rd_state_d = StIdle;
    endcase
  end

  // Output logic: memory strobes, address updates and error detection.
  always_comb begin
    mem_we    = !rst && is_wr_data && (wr_state_q == StArmed);
    mem_re    = !rst && is_rd_data && (rd_state_q == StArmed);
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    if (is_wr_addr && addr_ok) begin
      wr_addr_d = pay_addr;
    end else if (mem_we && (AUTO_INC != 0)) begin
      wr_addr_d = next_addr(wr_addr_q);
    end
    if (is_rd_addr && addr_ok) begin
      rd_addr_d = pay_addr;
    end else if (mem_re && (AUTO_INC != 0)) begin
      rd_addr_d = next_addr(rd_addr_q);
    end
    err_d = (is_wr_data && (wr_state_q == StIdle)) ||
            (is_rd_data && (rd_state_q == StIdle)) ||
            ((is_wr_addr || is_rd_addr) && !addr_ok);
  end

  ram_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_ram_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we),
    .waddr_i(wr_addr_q),
    .wdata_i(din[DATA_W-1:0]),
    .re_i   (mem_re),
    .raddr_i(rd_addr_q),
    .rdata_o(dout)
  );

  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width and payload width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; legal range 1..DATA_W.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of words; legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter AUTO_INC, default 0, where 1 enables post-access address increment (burst).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port din, input, DATA_W+2, with din[DATA_W+1:DATA_W] as command and din[DATA_W-1:0] as payload.
REQ-008 SHALL have port rx_valid, input, 1, which qualifies din for one cycle.
REQ-009 SHALL have port dout, output, DATA_W, the read data.
REQ-010 SHALL have port tx_valid, output, 1, which marks dout valid for one cycle.
REQ-011 SHALL have port err, output, 1, a one-cycle protocol/range error pulse.

Function
REQ-012 SHALL ignore din whenever rx_valid=0; no state changes and all outputs keep their idle values.
REQ-013 SHALL decode the command as 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-014 SHALL, on WR_ADDR, load wr_addr=payload[ADDR_W-1:0] and set wr_armed.
REQ-015 SHALL, on WR_DATA with wr_armed=1, write payload to mem[wr_addr] at that edge.
REQ-016 SHALL, on RD_ADDR, load rd_addr=payload[ADDR_W-1:0] and set rd_armed.
REQ-017 SHALL, on RD_DATA with rd_armed=1 at edge N, drive dout=mem[rd_addr] and tx_valid=1 at edge N+1; payload is ignored.
REQ-018 SHALL hold tx_valid high for exactly one cycle per accepted RD_DATA; dout holds its last value otherwise.
REQ-019 SHALL keep tx_valid=0 in the cycle after any command other than an accepted RD_DATA.
REQ-020 SHALL keep armed flags and addresses set after an access, so repeat WR_DATA/RD_DATA reuse the address when AUTO_INC=0.
REQ-021 SHALL, when AUTO_INC=1, increment wr_addr after each accepted WR_DATA and rd_addr after each accepted RD_DATA.
REQ-022 SHALL wrap an incremented address from MEM_DEPTH-1 to 0.
REQ-023 SHALL pulse err at N+1, with no memory write and tx_valid staying 0, for WR_DATA while wr_armed=0 or RD_DATA while rd_armed=0.
REQ-024 SHALL, for WR_ADDR/RD_ADDR with address >= MEM_DEPTH, pulse err at N+1, leave the address unchanged and clear the corresponding armed flag.
REQ-025 SHALL let a read and a write to the same address in successive cycles return the newly written data.
REQ-026 SHALL keep read-side and write-side state independent; interleaving is legal.
REQ-027 SHALL implement the per-side control as FSM states IDLE (not armed) and ARMED, per REQ-014..024.
REQ-028 SHALL produce err and tx_valid that are never both 1 in the same cycle.

Reset
REQ-029 SHALL, on rst=1 at an edge, drive dout=0, tx_valid=0 and err=0 at the next cycle.
REQ-030 SHALL, on reset, clear wr_addr, rd_addr, wr_armed and rd_armed; memory contents are not cleared.
REQ-031 SHALL let reset override a same-cycle command; a RD_DATA in the reset cycle produces no tx_valid.

Structure
REQ-032 SHALL place cmd_e (the four command codes) and the reset value constants in shared package ram_pkg.
REQ-033 SHALL place storage in sub-module ram_array (one write port, one synchronous read port, parametrised DATA_W/MEM_DEPTH).
REQ-034 SHALL keep the command FSM, address registers, increment/wrap and error logic in param_ram.

Verification
REQ-035 SHALL verify basic write/read with defaults: WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA -> dout=0xA5, tx_valid=1 for one cycle, err=0.
REQ-036 SHALL verify burst wrap with AUTO_INC=1, MEM_DEPTH=16, ADDR_W=4: WR_ADDR 0xE, WR_DATA 1, 2, 3 -> mem[14]=1, mem[15]=2, mem[0]=3; reading from RD_ADDR 0xE returns 1, 2, 3.
REQ-037 SHALL verify the unarmed error: after reset, RD_DATA -> err=1 one cycle, tx_valid=0; WR_DATA 0x55 -> err=1 and mem unchanged.
REQ-038 SHALL verify range error with MEM_DEPTH=200: RD_ADDR 0xC8 -> err=1; a following RD_DATA -> err=1, tx_valid=0.
REQ-039 SHALL verify reset mid-operation: RD_ADDR 0x03, then RD_DATA with rst=1 in the same cycle -> tx_valid=0, dout=0; a following RD_DATA -> err=1.
REQ-040 SHALL verify the rx_valid gate: commands with rx_valid=0 cause no write, no tx_valid and no err.
